regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of the register file write port and of every data input/output.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive cycles port B may wait before it is forced a grant; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 a_valid  input  1  pipeline writeback request.
REQ-006 a_rd  input  5  port A destination register.
REQ-007 a_data  input  WIDTH  port A write data.
REQ-008 a_ready  output  1  port A request accepted this cycle.
REQ-009 b_valid  input  1  long-latency unit writeback request; held with stable b_rd/b_data until accepted.
REQ-010 b_rd  input  5  port B destination register.
REQ-011 b_data  input  WIDTH  port B write data.
REQ-012 b_ready  output  1  port B request accepted this cycle.
REQ-013 iss_valid  input  1  issue of an operation to the long-latency unit.
REQ-014 iss_rd  input  5  destination register of the issued operation.
REQ-015 iss_ready  output  1  issue accepted; combinational, equals 0 when busy[iss_rd] is 1 and iss_rd is nonzero, otherwise 1.
REQ-016 rs1_addr, rs2_addr  input  5 each  source registers being decoded.
REQ-017 rs1_busy, rs2_busy  output  1 each  source has a pending port B write; combinational.
REQ-018 rf_we, rf_rd, rf_wdata  output  1 / 5 / WIDTH  registered write port driving the register file regWrite, rd_addr, write_data.

Function
REQ-019 Handshake completes on a port in a cycle when its valid and ready are both 1; at most one port completes per cycle.
REQ-020 Normal priority: a_ready = a_valid and not force_b; b_ready = b_valid and (not a_valid or force_b).
REQ-021 force_b is a registered flag equal to 1 when wait_cnt has reached STARVE_LIMIT.
REQ-022 wait_cnt (4 bits): increments each cycle with b_valid=1 and b_ready=0, saturates at STARVE_LIMIT, clears to 0 on a port B handshake or when b_valid=0.
REQ-023 Completed handshake at cycle N drives rf_rd/rf_wdata with the winner's rd/data and rf_we=1 in cycle N+1 (latency 1); without a handshake rf_we=0 in N+1 and rf_rd/rf_wdata hold.
REQ-024 Handshake with destination 0 completes normally but produces rf_we=0.
REQ-025 Scoreboard: 32 busy bits, bit 0 constant 0.
REQ-026 busy[iss_rd] sets on the edge after iss_valid and iss_ready are both 1, iss_rd nonzero.
REQ-027 busy[b_rd] clears on the edge after a port B handshake.
REQ-028 Same-cycle issue to register r and port B completion of r: the set wins and busy[r] ends at 1.
REQ-029 rsN_busy = busy[rsN_addr]; address 0 always yields 0.
REQ-030 Port A writes never modify busy bits.

Reset
REQ-031 While rst_n=0: rf_we=0, rf_rd=0, rf_wdata=0, all busy bits 0, wait_cnt=0, force_b=0; asserts immediately, independent of clk.
REQ-032 Reset mid-operation discards any pending grant: no rf_we pulse in the first cycle after release.
REQ-033 While rst_n=0, a_ready and b_ready are 0 and iss_ready is 1.

Verification
REQ-034 a_valid=1 rd=3 data=0xAAAA0001 alone -> a_ready=1; next cycle rf_we=1, rf_rd=3, rf_wdata=0xAAAA0001.
REQ-035 a_valid and b_valid held every cycle with STARVE_LIMIT=4 -> A granted 4 cycles, then B granted with a_ready=0; wait_cnt returns to 0.
REQ-036 Issue rd=7 -> rs1_addr=7 gives rs1_busy=1 and a second issue to 7 sees iss_ready=0; B completes rd=7 -> busy clears the next cycle.
REQ-037 Same cycle: issue rd=5 and B completes rd=5 -> busy[5] remains 1.
REQ-038 A write to rd=0 -> handshake completes, rf_we stays 0; rs1_addr=0 -> rs1_busy=0.
REQ-039 rst_n pulsed low for half a cycle during a B grant -> outputs clear immediately, no rf_we after release, all busy bits 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single register-file write port.
// Port A is the in-order pipeline and normally has priority. Port B is a
// long-latency unit that gets a forced grant once it has waited long enough.
// A busy scoreboard tracks destinations with an outstanding port B write so
// decode can stall on hazards and issue can refuse a second writer.
module regfile_wb_arbiter #(
   parameter int WIDTH        = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             a_valid,
   input  logic [4:0]       a_rd,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,

   input  logic             b_valid,
   input  logic [4:0]       b_rd,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,

   input  logic             iss_valid,
   input  logic [4:0]       iss_rd,
   output logic             iss_ready,

   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   output logic             rs1_busy,
   output logic             rs2_busy,

   output logic             rf_we,
   output logic [4:0]       rf_rd,
   output logic [WIDTH-1:0] rf_wdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]  wait_cnt;
   logic [3:0]  wait_nxt;
   logic        force_b;
   logic        force_nxt;
   logic        a_hs;
   logic        b_hs;
   logic        iss_hs;
   logic [31:1] busy_q;
   logic [31:1] busy_nxt;
   logic [31:0] busy_vec;

   // Register 0 can never be busy, so its bit is a hard zero.
   assign busy_vec = {busy_q, 1'b0};

   // Grant decode. Readies are suppressed while reset is asserted so no
   // handshake can be seen by either producer during reset.
   always_comb begin
      a_ready   = rst_n & a_valid & ~force_b;
      b_ready   = rst_n & b_valid & (~a_valid | force_b);
      a_hs      = a_ready;
      b_hs      = b_ready;
      iss_ready = ~((iss_rd != 5'd0) & busy_vec[iss_rd]);
      iss_hs    = iss_valid & iss_ready & (iss_rd != 5'd0);
      rs1_busy  = busy_vec[rs1_addr];
      rs2_busy  = busy_vec[rs2_addr];
   end

   // Starvation timer: counts refused port B cycles up to the limit. force_b
   // is registered alongside it so the grant decode sees no counter compare.
   always_comb begin
      wait_nxt = 4'd0;
      if (b_valid && !b_ready) begin
         if (wait_cnt >= LIMIT)
            wait_nxt = LIMIT;
         else
            wait_nxt = wait_cnt + 4'd1;
      end
      force_nxt = (wait_nxt == LIMIT);
   end

   // Starvation timer and force flag state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 4'd0;
         force_b  <= 1'b0;
      end else begin
         wait_cnt <= wait_nxt;
         force_b  <= force_nxt;
      end
   end

   // Scoreboard update. The set is applied after the clear so a same-cycle
   // issue to a register that port B is retiring leaves it busy for the new
   // owner.
   always_comb begin
      busy_nxt = busy_q;
      for (int i = 1; i < 32; i++) begin
         if (b_hs && (b_rd == 5'(i)))
            busy_nxt[i] = 1'b0;
         if (iss_hs && (iss_rd == 5'(i)))
            busy_nxt[i] = 1'b1;
      end
   end

   // Scoreboard state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy_q <= '0;
      else
         busy_q <= busy_nxt;
   end

   // Registered write port: one cycle after a handshake the winner's
   // destination and data are presented. Writes to x0 are handshaken but not
   // enabled. Address and data hold when nothing completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_rd    <= 5'd0;
         rf_wdata <= '0;
      end else if (a_hs) begin
         rf_we    <= (a_rd != 5'd0);
         rf_rd    <= a_rd;
         rf_wdata <= a_data;
      end else if (b_hs) begin
         rf_we    <= (b_rd != 5'd0);
         rf_rd    <= b_rd;
         rf_wdata <= b_data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_regfile_wb_arbiter;

   localparam int WIDTH = 32;
   localparam int LIMIT = 4;

   logic             clk;
   logic             rst_n;
   logic             a_valid;
   logic [4:0]       a_rd;
   logic [WIDTH-1:0] a_data;
   logic             a_ready;
   logic             b_valid;
   logic [4:0]       b_rd;
   logic [WIDTH-1:0] b_data;
   logic             b_ready;
   logic             iss_valid;
   logic [4:0]       iss_rd;
   logic             iss_ready;
   logic [4:0]       rs1_addr;
   logic [4:0]       rs2_addr;
   logic             rs1_busy;
   logic             rs2_busy;
   logic             rf_we;
   logic [4:0]       rf_rd;
   logic [WIDTH-1:0] rf_wdata;

   regfile_wb_arbiter #(.WIDTH(WIDTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } rf_t;

   rf_t         exp_q[$];
   int          n_pass = 0;
   int          n_total = 0;

   // Reference model state.
   bit [31:0]   m_busy;
   int          m_wait;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   bit          last_a_ready;
   bit          last_b_ready;
   bit          last_eb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_busy = '0;
      m_wait = 0;
      m_rd   = '0;
      m_data = '0;
      exp_q.delete();
   endtask

   // One clock cycle of stimulus: drive, check combinational outputs against
   // the model, queue the expected write port contents, advance the model.
   task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                       input bit bv, input logic [4:0] brd, input logic [31:0] bdat,
                       input bit iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2);
      bit  frc, ea, eb, ei;
      rf_t e;
      @(negedge clk);
      a_valid = av; a_rd = ard; a_data = adat;
      b_valid = bv; b_rd = brd; b_data = bdat;
      iss_valid = iv; iss_rd = ird;
      rs1_addr = r1; rs2_addr = r2;
      #1;
      frc = (m_wait == LIMIT);
      ea  = av && !frc;
      eb  = bv && (!av || frc);
      ei  = !((ird != 0) && m_busy[ird]);
      chk("a_ready",   32'(a_ready),   32'(ea));
      chk("b_ready",   32'(b_ready),   32'(eb));
      chk("iss_ready", 32'(iss_ready), 32'(ei));
      chk("rs1_busy",  32'(rs1_busy),  32'((r1 != 0) && m_busy[r1]));
      chk("rs2_busy",  32'(rs2_busy),  32'((r2 != 0) && m_busy[r2]));
      last_a_ready = a_ready;
      last_b_ready = b_ready;
      last_eb      = eb;
      e.we = 1'b0;
      if (ea) begin
         e.we = (ard != 0); m_rd = ard; m_data = adat;
      end else if (eb) begin
         e.we = (brd != 0); m_rd = brd; m_data = bdat;
      end
      e.rd = m_rd; e.data = m_data;
      exp_q.push_back(e);
      if (eb) m_busy[brd] = 1'b0;
      if (iv && ei && ird != 0) m_busy[ird] = 1'b1;
      m_busy[0] = 1'b0;
      if (bv && !eb) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
      else m_wait = 0;
   endtask

   task automatic idle(input logic [4:0] r1);
      step(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
   endtask

   // Monitor: one expected write port entry per stepped cycle.
   initial begin
      rf_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we",    32'(rf_we),    32'(e.we));
            chk("rf_rd",    32'(rf_rd),    32'(e.rd));
            chk("rf_wdata", rf_wdata,      e.data);
         end
      end
   end

   initial begin
      bit          pend;
      logic [4:0]  p_rd;
      logic [31:0] p_data;
      bit          seq[5];
      a_valid = 0; a_rd = 0; a_data = 0;
      b_valid = 0; b_rd = 0; b_data = 0;
      iss_valid = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
      model_reset();
      rst_n = 1'b0;
      #2;
      a_valid = 1; b_valid = 1; iss_rd = 4;
      #1;
      chk("rst_rf_we",    32'(rf_we),     0);
      chk("rst_rf_rd",    32'(rf_rd),     0);
      chk("rst_rf_wdata", rf_wdata,       0);
      chk("rst_a_ready",  32'(a_ready),   0);
      chk("rst_b_ready",  32'(b_ready),   0);
      chk("rst_iss_rdy",  32'(iss_ready), 1);
      a_valid = 0; b_valid = 0; iss_rd = 0;
      #9 rst_n = 1'b1;

      // Port A alone.
      step(1, 3, 32'hAAAA0001, 0, 0, 0, 0, 0, 0, 0);
      chk("a_alone_ready", 32'(last_a_ready), 1);
      idle(0);

      // Starvation: A held with B held.
      for (int i = 0; i < 5; i++) begin
         step(1, 5'(10 + i), 32'h1000 + 32'(i), 1, 20, 32'hBBBB0020, 0, 0, 0, 0);
         seq[i] = last_a_ready;
      end
      for (int i = 0; i < 4; i++) chk("starve_a_win", 32'(seq[i]), 1);
      chk("starve_a_blocked", 32'(seq[4]), 0);
      chk("starve_b_forced",  32'(last_b_ready), 1);
      step(1, 11, 32'h2222, 1, 21, 32'hBBBB0021, 0, 0, 0, 0);
      chk("starve_cnt_clear", 32'(last_a_ready), 1);
      while (!last_eb) step(1, 11, 32'h2222, 1, 21, 32'hBBBB0021, 0, 0, 0, 0);
      idle(0);

      // Scoreboard on rd=7.
      step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      chk("busy7_rs1", 32'(rs1_busy),  1);
      chk("busy7_iss", 32'(iss_ready), 0);
      step(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 7);
      step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      chk("busy7_clear", 32'(rs1_busy), 0);

      // Same-cycle issue and completion of rd=5.
      step(0, 0, 0, 1, 5, 32'h55, 1, 5, 0, 0);
      idle(5);
      chk("busy5_set_wins", 32'(rs1_busy), 1);
      step(0, 0, 0, 1, 5, 32'h56, 0, 0, 0, 0);

      // Write to x0.
      step(1, 0, 32'hDEAD0000, 0, 0, 0, 0, 0, 0, 0);
      chk("x0_handshake", 32'(last_a_ready), 1);
      idle(0);
      chk("x0_rs1_busy", 32'(rs1_busy), 0);

      // Reset pulse during a B grant with busy bits outstanding.
      step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
      idle(9);
      @(negedge clk);
      b_valid = 1; b_rd = 9; b_data = 32'h99;
      #1;
      chk("pre_rst_b_ready", 32'(b_ready), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rf_we", 32'(rf_we),    0);
      chk("mid_rst_rf_rd", 32'(rf_rd),    0);
      chk("mid_rst_b_rdy", 32'(b_ready),  0);
      chk("mid_rst_busy",  32'(dut.busy_vec), 0);
      b_valid = 0;
      #4 rst_n = 1'b1;
      model_reset();
      idle(9);
      chk("post_rst_rs1", 32'(rs1_busy), 0);
      idle(0);

      // Randomized traffic; port B holds its request until accepted.
      pend = 0; p_rd = 0; p_data = 0;
      for (int n = 0; n < 400; n++) begin
         bit av, iv;
         if (!pend && ($urandom_range(0, 1) == 1)) begin
            pend = 1; p_rd = 5'($urandom_range(0, 31)); p_data = $urandom;
         end
         av = ($urandom_range(0, 2) != 0);
         iv = ($urandom_range(0, 2) == 0);
         step(av, 5'($urandom_range(0, 31)), $urandom,
              pend, pend ? p_rd : 5'd0, pend ? p_data : 32'd0,
              iv, 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         if (last_eb) pend = 0;
      end
      idle(0);
      idle(0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
